// File: rtl/alu_requester.sv
// Credit-based initiator/collector for a fixed-latency alu: issues ops and tracks them in order.
// It returns each result with its op/tag on a registered valid/ready response port.
module alu_requester #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ALU_LATENCY = 2,
  parameter int unsigned STAMP_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [1:0]       rsp_op,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             err_unexpected,
  output logic             err_latency,
  input  logic             err_clear
);

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_RSV = 2'd3
  } operation_t;

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEPTH);
  localparam logic [STAMP_W-1:0] LAT_C   = STAMP_W'(ALU_LATENCY);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STAMP_W-1:0] stamp_q;

  operation_t         alu_op_q;
  logic [WIDTH-1:0]   alu_a_q, alu_b_q;
  logic               alu_in_valid_q;
  logic [TAG_W-1:0]   iss_tag_q;

  logic [1:0]         trk_op_q    [DEPTH];
  logic [TAG_W-1:0]   trk_tag_q   [DEPTH];
  logic [STAMP_W-1:0] trk_stamp_q [DEPTH];
  logic [PTR_W:0]     trk_wr_q, trk_rd_q;

  logic [WIDTH-1:0]   res_data_q [DEPTH];
  logic [1:0]         res_op_q   [DEPTH];
  logic [TAG_W-1:0]   res_tag_q  [DEPTH];
  logic [PTR_W:0]     res_wr_q, res_rd_q;

  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [1:0]         rsp_op_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic               err_unexp_q, err_lat_q;

  logic               accept, rsp_hs;
  logic               trk_empty, res_empty;
  logic               ret_ok, unexp, lat_bad;
  logic               load_out, res_pop, res_push;
  logic [PTR_W-1:0]   trk_wr_idx, trk_rd_idx, res_wr_idx, res_rd_idx;
  logic [STAMP_W-1:0] age;

  assign req_ready  = !rst && (cnt_q < CNT_MAX);
  assign accept     = req_valid && req_ready;
  assign rsp_hs     = rsp_valid_q && rsp_ready;

  assign trk_wr_idx = trk_wr_q[PTR_W-1:0];
  assign trk_rd_idx = trk_rd_q[PTR_W-1:0];
  assign res_wr_idx = res_wr_q[PTR_W-1:0];
  assign res_rd_idx = res_rd_q[PTR_W-1:0];
  assign trk_empty  = (trk_wr_q == trk_rd_q);
  assign res_empty  = (res_wr_q == res_rd_q);

  // Age wraps modulo 2**STAMP_W, so a plain subtraction is exact.
  assign age        = stamp_q - trk_stamp_q[trk_rd_idx];
  assign ret_ok     = alu_out_valid && !trk_empty;
  assign unexp      = alu_out_valid && trk_empty;
  assign lat_bad    = ret_ok && (age != LAT_C);

  // The output register is refilled from the FIFO head first; an arriving result
  // bypasses straight into it only when the FIFO is empty, keeping issue order.
  assign load_out   = !rsp_valid_q || rsp_ready;
  assign res_pop    = load_out && !res_empty;
  assign res_push   = ret_ok && !(load_out && res_empty);

  always_comb begin
    cnt_d = cnt_q;
    if (accept && !rsp_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!accept && rsp_hs) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      stamp_q        <= '0;
      alu_op_q       <= OP_NOP;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_in_valid_q <= 1'b0;
      iss_tag_q      <= '0;
      trk_wr_q       <= '0;
      trk_rd_q       <= '0;
      res_wr_q       <= '0;
      res_rd_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_op_q       <= '0;
      rsp_tag_q      <= '0;
      err_unexp_q    <= 1'b0;
      err_lat_q      <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      stamp_q        <= stamp_q + STAMP_W'(1);
      alu_in_valid_q <= accept;
      alu_op_q       <= accept ? operation_t'(req_op) : OP_NOP;
      alu_a_q        <= accept ? req_a : '0;
      alu_b_q        <= accept ? req_b : '0;
      iss_tag_q      <= accept ? req_tag : '0;
      if (alu_in_valid_q) trk_wr_q <= trk_wr_q + 1'b1;
      if (ret_ok)         trk_rd_q <= trk_rd_q + 1'b1;
      if (res_push)       res_wr_q <= res_wr_q + 1'b1;
      if (res_pop)        res_rd_q <= res_rd_q + 1'b1;
      if (load_out) begin
        if (!res_empty) begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= res_data_q[res_rd_idx];
          rsp_op_q    <= res_op_q[res_rd_idx];
          rsp_tag_q   <= res_tag_q[res_rd_idx];
        end else if (ret_ok) begin
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= alu_out;
          rsp_op_q    <= trk_op_q[trk_rd_idx];
          rsp_tag_q   <= trk_tag_q[trk_rd_idx];
        end else begin
          rsp_valid_q <= 1'b0;
        end
      end
      err_unexp_q <= unexp   || (err_unexp_q && !err_clear);
      err_lat_q   <= lat_bad || (err_lat_q && !err_clear);
    end
  end

  always_ff @(posedge clk) begin
    if (alu_in_valid_q) begin
      trk_op_q[trk_wr_idx]    <= alu_op_q;
      trk_tag_q[trk_wr_idx]   <= iss_tag_q;
      trk_stamp_q[trk_wr_idx] <= stamp_q;
    end
    if (res_push) begin
      res_data_q[res_wr_idx] <= alu_out;
      res_op_q[res_wr_idx]   <= trk_op_q[trk_rd_idx];
      res_tag_q[res_wr_idx]  <= trk_tag_q[trk_rd_idx];
    end
  end

  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_in_valid   = alu_in_valid_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_op         = rsp_op_q;
  assign rsp_tag        = rsp_tag_q;
  assign err_unexpected = err_unexp_q;
  assign err_latency    = err_lat_q;

endmodule

// File: tb/tb_alu_requester.sv
// Scoreboard bench for alu_requester with a behavioural 2-cycle alu that can be
// delayed by one cycle or have its out_valid forced.
module tb_alu_requester;

  typedef struct {
    logic [1:0] op;
    logic [5:0] a;
    logic [5:0] b;
    logic [3:0] tag;
    logic [5:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic [5:0] req_a, req_b;
  logic [3:0] req_tag;
  logic [1:0] alu_op;
  logic [5:0] alu_a, alu_b;
  logic       alu_in_valid;
  logic [5:0] alu_out;
  logic       alu_out_valid;
  logic       rsp_valid, rsp_ready;
  logic [5:0] rsp_data;
  logic [1:0] rsp_op;
  logic [3:0] rsp_tag;
  logic       err_unexpected, err_latency, err_clear;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  vec_t exp_q[$];

  logic       force_v = 1'b0;
  logic       extra   = 1'b0;
  logic       s1_v = 1'b0, s2_v = 1'b0, s3_v = 1'b0;
  logic [5:0] s1_d = '0, s2_d = '0, s3_d = '0;

  alu_requester #(
    .WIDTH(6), .TAG_W(4), .DEPTH(4), .ALU_LATENCY(2), .STAMP_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_op(rsp_op), .rsp_tag(rsp_tag),
    .err_unexpected(err_unexpected), .err_latency(err_latency), .err_clear(err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] alu_fn(input logic [1:0] op, input logic [5:0] a, input logic [5:0] b);
    case (op)
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return 6'd0;
    endcase
  endfunction

  // Alu stand-in: not reset, so results in flight survive a requester reset.
  always @(posedge clk) begin
    s1_v <= alu_in_valid;
    s1_d <= alu_fn(alu_op, alu_a, alu_b);
    s2_v <= s1_v;
    s2_d <= s1_d;
    s3_v <= s2_v;
    s3_d <= s2_d;
  end
  assign alu_out_valid = force_v | (extra ? s3_v : s2_v);
  assign alu_out       = force_v ? 6'd42 : (extra ? s3_d : s2_d);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  logic       hold_prev = 1'b0;
  logic [5:0] h_data;
  logic [1:0] h_op;
  logic [3:0] h_tag;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) chk("rsp_hold", {rsp_valid, rsp_data, rsp_op, rsp_tag}, {1'b1, h_data, h_op, h_tag});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          chk("rsp_data", rsp_data, e.exp);
          chk("rsp_op", rsp_op, e.op);
          chk("rsp_tag", rsp_tag, e.tag);
        end
      end
      hold_prev = rsp_valid && !rsp_ready;
      h_data = rsp_data;
      h_op   = rsp_op;
      h_tag  = rsp_tag;
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    int n;
    req_op = v.op; req_a = v.a; req_b = v.b; req_tag = v.tag;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (req_ready) exp_q.push_back(v);
    else chk("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  vec_t v;
  vec_t v3[6];
  int   lat, acc, idx, t0;

  initial begin
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b0; err_clear = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_alu_in_valid", alu_in_valid, 0);
    chk("rst_alu_op_ab", {alu_op, alu_a, alu_b}, 0);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_op, rsp_tag}, 0);
    chk("rst_errs", {err_unexpected, err_latency}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // add with latency measurement
    rsp_ready = 1'b1;
    v = '{2'd1, 6'd5, 6'd3, 4'd7, 6'd8};
    send(v);
    @(negedge clk);
    chk("issue_valid", alu_in_valid, 1);
    chk("issue_op_ab", {alu_op, alu_a, alu_b}, {2'd1, 6'd5, 6'd3});
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_latency", lat, 4);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_alu_in_valid", alu_in_valid, 0);
    @(posedge clk); #1;

    // subtract with wrap
    v = '{2'd2, 6'd2, 6'd5, 4'd3, 6'd61};
    send(v);
    wait_drain(20);
    chk("sub_no_errs", {err_unexpected, err_latency}, 0);

    // backpressure: only DEPTH accepts, then drain one per cycle
    v3[0] = '{2'd0, 6'd9,  6'd9, 4'd1, 6'd0};
    v3[1] = '{2'd1, 6'd63, 6'd1, 4'd2, 6'd0};
    v3[2] = '{2'd3, 6'd7,  6'd7, 4'd3, 6'd0};
    v3[3] = '{2'd2, 6'd10, 6'd4, 4'd4, 6'd6};
    v3[4] = '{2'd1, 6'd20, 6'd22, 4'd5, 6'd42};
    v3[5] = '{2'd2, 6'd0,  6'd1, 4'd6, 6'd63};
    rsp_ready = 1'b0;
    idx = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      req_op = v3[idx].op; req_a = v3[idx].a; req_b = v3[idx].b; req_tag = v3[idx].tag;
      req_valid = 1'b1;
      @(negedge clk);
      if (req_ready) begin
        exp_q.push_back(v3[idx]);
        idx++;
        acc++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("bp_accepts", acc, 4);
    @(negedge clk);
    chk("bp_req_ready_low", req_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_rsp_waiting", rsp_valid, 1);
    chk("bp_still_full", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_valid", rsp_valid, 1);
      if (k == 0) chk("drain_ready_k0", req_ready, 0);
      if (k == 1) chk("drain_ready_k1", req_ready, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_done", rsp_valid, 0);
    @(posedge clk); #1;

    // continuous stream across stamp wrap
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      v.op  = (i % 2 == 0) ? 2'd1 : 2'd2;
      v.a   = 6'(i * 3);
      v.b   = 6'd5;
      v.tag = 4'(i);
      v.exp = (i % 2 == 0) ? 6'(i * 3 + 5) : 6'(i * 3 - 5);
      send(v);
    end
    chk("stream_min_cycles", (cyc - t0) >= 20, 1);
    chk("stream_max_cycles", (cyc - t0) <= 26, 1);
    wait_drain(20);
    chk("stream_no_errs", {err_unexpected, err_latency}, 0);

    // unexpected result, set-wins, clear
    force_v = 1'b1;
    @(posedge clk); #1;
    force_v = 1'b0;
    @(negedge clk);
    chk("unexp_set", err_unexpected, 1);
    chk("unexp_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    force_v = 1'b1; err_clear = 1'b1;
    @(posedge clk); #1;
    force_v = 1'b0;
    @(negedge clk);
    chk("unexp_set_wins", err_unexpected, 1);
    @(posedge clk); #1;
    err_clear = 1'b0;
    @(negedge clk);
    chk("unexp_cleared", err_unexpected, 0);
    chk("unexp_no_rsp2", rsp_valid, 0);
    @(posedge clk); #1;

    // late alu result: flagged but still returned
    extra = 1'b1;
    v = '{2'd1, 6'd1, 6'd2, 4'd9, 6'd3};
    send(v);
    wait_drain(20);
    chk("late_err_latency", err_latency, 1);
    chk("late_no_unexp", err_unexpected, 0);
    extra = 1'b0;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    @(negedge clk);
    chk("late_cleared", err_latency, 0);
    @(posedge clk); #1;

    // reset with ops in flight
    v = '{2'd1, 6'd1, 6'd1, 4'd1, 6'd2};
    send(v);
    v = '{2'd1, 6'd2, 6'd2, 4'd2, 6'd4};
    send(v);
    v = '{2'd1, 6'd3, 6'd3, 4'd3, 6'd6};
    send(v);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsp", {rsp_valid, rsp_data, rsp_op, rsp_tag}, 0);
    chk("mid_rst_alu", {alu_in_valid, alu_op, alu_a, alu_b}, 0);
    chk("mid_rst_errs", {err_unexpected, err_latency}, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stale_unexp", err_unexpected, 1);
    chk("stale_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
